// File: rtl/adc_sample_scheduler.sv
// Periodic ADC conversion scheduler: period timer, trigger/capture FSM and sample FIFO.
// Define ADC_SCHED_TIMEOUT_EN to compile in the WAIT_BUSY watchdog and adc_timeout flag.
module adc_sample_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MIN_PERIOD   = 128,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] rate_div,
    input  logic        clear_flags,
    output logic        adc_trigger,
    input  logic        adc_busy,
    input  logic [7:0]  adc_sample,
    output logic [7:0]  sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [4:0]  fifo_level,
    output logic        overrun,
    output logic        tick_slip,
    output logic        adc_timeout
);

    // state     | meaning
    // IDLE      | waiting for a tick or a pending tick
    // TRIGGER   | one-cycle conversion-start pulse
    // WAIT_BUSY | waiting for the ADC to raise adc_busy
    // CONVERT   | conversion in progress, waiting for adc_busy to fall
    // CAPTURE   | push the registered sample into the FIFO

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] MIN_P   = 16'(MIN_PERIOD);
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (MIN_PERIOD < 1) || (MIN_PERIOD > 65535) || (BUSY_TIMEOUT < 1) || (BUSY_TIMEOUT > 65535))
    begin : g_bad_param
        $error("adc_sample_scheduler: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_BUSY,
        CONVERT,
        CAPTURE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] period, per_cnt;
    logic        tick, pending, slip_set;
    logic        push, pop, full, push_ok, overrun_set, wd_expired;
    logic [7:0]  cap_data;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]  level;

    // Comparing with >= keeps ticks coming if rate_div shrinks below the running count.
    assign period = (rate_div < MIN_P) ? MIN_P : rate_div;
    assign tick   = run && (per_cnt >= period - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (!run || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 16'd1;
        end
    end

    assign slip_set = tick && (state != IDLE) && pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (!run || (state == IDLE)) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LOAD = 16'(BUSY_TIMEOUT - 1);
    logic [15:0] wd_cnt;
    logic        timeout_set, timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == TRIGGER) begin
            wd_cnt <= WD_LOAD;
        end else if ((state == WAIT_BUSY) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - 16'd1;
        end
    end

    assign wd_expired  = (wd_cnt == '0);
    assign timeout_set = (state == WAIT_BUSY) && !adc_busy && wd_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_set | (timeout_q & ~clear_flags);
        end
    end

    assign adc_timeout = timeout_q;
`else
    assign wd_expired  = 1'b0;
    assign adc_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE:      if (run && (tick || pending)) state_nxt = TRIGGER;
            TRIGGER:   state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (adc_busy) begin
                    state_nxt = CONVERT;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            CONVERT:   if (!adc_busy) state_nxt = CAPTURE;
            CAPTURE: begin
                push      = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    assign adc_trigger = (state == TRIGGER);

    // Sample is taken on the cycle adc_busy is first seen low, then pushed from CAPTURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_data <= '0;
        end else if ((state == CONVERT) && !adc_busy) begin
            cap_data <= adc_sample;
        end
    end

    assign full         = (level == DEPTH_L);
    assign sample_valid = (level != 5'd0);
    assign pop          = sample_valid && sample_ready;
    assign push_ok      = push && (!full || pop);
    assign overrun_set  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= cap_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    assign sample_data = mem[rd_ptr];
    assign fifo_level  = level;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            tick_slip <= 1'b0;
        end else begin
            overrun   <= overrun_set | (overrun & ~clear_flags);
            tick_slip <= slip_set | (tick_slip & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Randomized bench for adc_sample_scheduler with a behavioural ADC and a queue-based FIFO model.
// The watchdog section follows whether ADC_SCHED_TIMEOUT_EN is defined.
module tb_adc_sample_scheduler;

    localparam int DEPTH = 4;
    localparam int MINP  = 128;

    logic        clk = 1'b0;
    logic        reset, run, clear_flags, adc_busy, sample_ready;
    logic [15:0] rate_div;
    logic [7:0]  adc_sample, sample_data;
    logic        adc_trigger, sample_valid, overrun, tick_slip, adc_timeout;
    logic [4:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    bit adc_en     = 1'b1;
    int busy_len   = 70;
    bit rand_ready = 1'b0;

    int         cyc = 0;
    int         trig_t[$];
    logic [7:0] mq[$];
    bit         exp_ov = 1'b0;

    always #5 clk = ~clk;

    adc_sample_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .MIN_PERIOD  (MINP),
        .BUSY_TIMEOUT(255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .rate_div    (rate_div),
        .clear_flags (clear_flags),
        .adc_trigger (adc_trigger),
        .adc_busy    (adc_busy),
        .adc_sample  (adc_sample),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .tick_slip   (tick_slip),
        .adc_timeout (adc_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ADC: busy rises one clock after the trigger, stays high busy_len clocks, then a new sample appears.
    initial begin
        adc_busy   = 1'b0;
        adc_sample = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (adc_en && adc_trigger) begin
                @(posedge clk);
                #1 adc_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 adc_busy = 1'b0;
                adc_sample = 8'($urandom);
            end
        end
    end

    // Scoreboard: compare against the model, then apply what the coming clock edge will do.
    initial begin
        bit         pop, drop, full_before, live, prev_busy, prev_trig;
        int         cap_age;
        logic [7:0] cap_val;
        live = 0; prev_busy = 0; prev_trig = 0; cap_age = 0; cap_val = '0;
        forever begin
            @(negedge clk);
            cyc++;
            check("level", fifo_level, mq.size());
            check("valid", sample_valid, mq.size() != 0);
            if (mq.size() != 0) check("head", sample_data, mq[0]);
            check("overrun", overrun, exp_ov);
            if (adc_trigger) begin
                trig_t.push_back(cyc);
                check("trig_width", prev_trig, 0);
            end
            if (reset) begin
                mq.delete();
                exp_ov  = 1'b0;
                live    = 1'b0;
                cap_age = 0;
            end else begin
                full_before = (mq.size() == DEPTH);
                pop  = sample_ready && (mq.size() != 0);
                drop = 1'b0;
                if (pop) void'(mq.pop_front());
                if (cap_age == 1) begin
                    cap_age = 0;
                    if (full_before && !pop) drop = 1'b1;
                    else mq.push_back(cap_val);
                end
                exp_ov = drop ? 1'b1 : (clear_flags ? 1'b0 : exp_ov);
                if (adc_trigger) live = 1'b1;
                // sample is in the FIFO two clocks after adc_busy falls
                if (prev_busy && !adc_busy && live) begin
                    cap_age = 1;
                    cap_val = adc_sample;
                    live    = 1'b0;
                end
            end
            prev_busy = adc_busy;
            prev_trig = adc_trigger;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_trigs(input int base, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((trig_t.size() < base + n) && (k < budget)) begin
            step(1);
            k++;
        end
        check(tag, trig_t.size() - base >= n, 1);
    endtask

    task automatic check_period(input int rate, input int busy, input int ntrig, input string tag);
        int p, base, c;
        p        = (rate < MINP) ? MINP : rate;
        busy_len = busy;
        rate_div = 16'(rate);
        base     = trig_t.size();
        run      = 1'b1;
        c        = cyc;
        wait_trigs(base, ntrig, (ntrig + 1) * p + 50, {tag, "_count"});
        if (trig_t.size() > base) check({tag, "_first"}, trig_t[base] - c, p + 1);
        for (int i = base + 1; (i < trig_t.size()) && (i < base + ntrig); i++)
            check({tag, "_period"}, trig_t[i] - trig_t[i-1], p);
        run = 1'b0;
        step(busy + 20);
    endtask

    initial begin
        int         base, k;
        logic [7:0] first_val, second_val;
        reset = 1'b1; run = 1'b0; clear_flags = 1'b0; sample_ready = 1'b0; rate_div = 16'd0;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_trigger", adc_trigger, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_data", sample_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_slip", tick_slip, 0);
        check("rst_timeout", adc_timeout, 0);

        sample_ready = 1'b1;
        check_period(1000, 70, 4, "r1000");
        check_period(10, 70, 3, "r10");

        rand_ready = 1'b1;
        for (int it = 0; it < 4; it++)
            check_period($urandom_range(0, 400), $urandom_range(5, 90), 3, "rand");
        rand_ready   = 1'b0;
        sample_ready = 1'b1;
        step(10);

        // Conversions longer than the period: pending tick re-triggers right after capture.
        busy_len = 300;
        rate_div = 16'd128;
        base     = trig_t.size();
        run      = 1'b1;
        wait_trigs(base, 4, 2000, "slip_count");
        for (int i = base + 1; (i < trig_t.size()) && (i < base + 4); i++)
            check("slip_b2b", (trig_t[i] - trig_t[i-1] >= 300) && (trig_t[i] - trig_t[i-1] <= 310), 1);
        check("slip_flag", tick_slip, 1);
        run  = 1'b0;
        base = trig_t.size();
        step(400);
        check("run_stop_no_trig", trig_t.size(), base);
        check("slip_sticky", tick_slip, 1);
        check("run_stop_drained", fifo_level, 0);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("slip_clear", tick_slip, 0);

        // Overrun: five conversions into a four-deep FIFO with no consumer.
        sample_ready = 1'b0;
        busy_len     = 20;
        rate_div     = 16'd128;
        base         = trig_t.size();
        run          = 1'b1;
        wait_trigs(base, 5, 900, "ovr_count");
        step(40);
        run = 1'b0;
        check("ovr_level", fifo_level, DEPTH);
        check("ovr_flag", overrun, 1);
        first_val = mq[0];
        check("ovr_head", sample_data, first_val);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("ovr_clear", overrun, 0);

        // Full FIFO, consumer pops exactly in the CAPTURE cycle.
        second_val = mq[1];
        run = 1'b1;
        k   = 0;
        while ((adc_busy !== 1'b1) && (k < 600)) begin @(negedge clk); k++; end
        while ((adc_busy !== 1'b0) && (k < 600)) begin @(negedge clk); k++; end
        check("pp_busy_seen", k < 600, 1);
        @(posedge clk);
        #1 sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
        run = 1'b0;
        check("pp_level", fifo_level, DEPTH);
        check("pp_overrun", overrun, 0);
        check("pp_head", sample_data, second_val);
        sample_ready = 1'b1;
        step(10);
        check("pp_drain", fifo_level, 0);

        // ADC never answers.
        adc_en   = 1'b0;
        rate_div = 16'd128;
        base     = trig_t.size();
        run      = 1'b1;
        wait_trigs(base, 1, 300, "wd_trig");
        run = 1'b0;
        step(250);
        check("wd_early", adc_timeout, 0);
        step(10);
`ifdef ADC_SCHED_TIMEOUT_EN
        check("wd_flag", adc_timeout, 1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("wd_clear", adc_timeout, 0);
`else
        check("wd_tied", adc_timeout, 0);
`endif
        check("wd_no_push", fifo_level, 0);

        // Reset in the middle of a conversion.
        reset = 1'b1;
        step(2);
        reset        = 1'b0;
        adc_en       = 1'b1;
        busy_len     = 100;
        sample_ready = 1'b0;
        base         = trig_t.size();
        run          = 1'b1;
        wait_trigs(base, 2, 400, "rst_trig");
        step(20);
        check("rstc_pre_level", fifo_level, 1);
        check("rstc_pre_busy", adc_busy, 1);
        reset = 1'b1;
        run   = 1'b0;
        step(1);
        check("rstc_trigger", adc_trigger, 0);
        check("rstc_valid", sample_valid, 0);
        check("rstc_level", fifo_level, 0);
        check("rstc_data", sample_data, 0);
        check("rstc_overrun", overrun, 0);
        check("rstc_slip", tick_slip, 0);
        check("rstc_timeout", adc_timeout, 0);
        reset = 1'b0;
        step(150);
        check("rstc_fall_ignored", fifo_level, 0);
        check("rstc_no_valid", sample_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_scheduler.md
ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, sample FIFO entries (power of two, 2..16).
REQ-002 Parameter: MIN_PERIOD, 128, minimum clocks between conversion starts.
REQ-003 Parameter: BUSY_TIMEOUT, 255, clocks allowed for adc_busy to respond.
REQ-004 Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = periodic sampling enabled.
- rate_div  in  16  clocks per sample period.
- clear_flags  in  1  pulse; clears the sticky flags.
- adc_trigger  out  1  one-cycle conversion-start pulse to the ADC interface (its get_rdid).
- adc_busy  in  1  ADC interface conversion-active level (its enable_adc).
- adc_sample  in  8  ADC channel sample; valid when adc_busy falls.
- sample_data  out  8  FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts head when sample_valid is 1.
- fifo_level  out  5  current FIFO occupancy.
- overrun  out  1  sticky; a sample was dropped because the FIFO was full.
- tick_slip  out  1  sticky; a sample tick arrived while a conversion was still in progress.
- adc_timeout  out  1  sticky; adc_busy did not respond in time.
REQ-005 The clock is clk and the reset is reset; reset is synchronous and active-high.

Function
REQ-006 Period counter: effective period P = max(rate_div, MIN_PERIOD); the counter counts clocks while run=1 and raises an internal tick every P clocks.
REQ-007 The first tick occurs P clocks after run rises; when run=0, the counter holds at 0 and no ticks occur.
REQ-008 FSM states: IDLE, TRIGGER, WAIT_BUSY, CONVERT, CAPTURE.
REQ-009 IDLE -> TRIGGER on a tick, or on a pending tick (see REQ-013).
REQ-010 TRIGGER: adc_trigger=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-011 WAIT_BUSY -> CONVERT when adc_busy=1; CONVERT -> CAPTURE on the first cycle adc_busy=0.
REQ-012 CAPTURE: register adc_sample and push it to the FIFO in that cycle, then go to IDLE; latency from adc_busy falling to sample_valid rising is at most 2 clocks.
REQ-013 A tick arriving in any non-IDLE state sets one pending flag; if the flag is already set, tick_slip is set and the tick is discarded. The pending flag is consumed on the next IDLE entry.
REQ-014 FIFO: push at the tail, pop on sample_valid & sample_ready; sample_data is the registered head.
REQ-015 Push with the FIFO full and no pop in the same cycle: drop the new sample, set overrun, leave the FIFO contents unchanged.
REQ-016 Push and pop in the same cycle with the FIFO full: both take effect; level stays FIFO_DEPTH; no overrun.
REQ-017 Push into an empty FIFO: sample_valid rises the next cycle; pop with the FIFO empty is ignored.
REQ-018 fifo_level is always in the range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-019 clear_flags clears overrun, tick_slip and adc_timeout; if a flag-setting event occurs in the same cycle, the set wins.
REQ-020 run falling mid-conversion: the current conversion completes and is captured; afterwards the FSM stays in IDLE and the pending flag is cleared.

Reset
REQ-021 On reset: FSM=IDLE, period counter=0, pending=0, FIFO empty (fifo_level=0, sample_valid=0, sample_data=0), adc_trigger=0, all sticky flags=0.
REQ-022 Reset asserted mid-conversion: the block returns to IDLE next clock; the in-flight sample is discarded; the ADC's subsequent adc_busy fall is ignored.

Configuration
REQ-023 Macro ADC_SCHED_TIMEOUT_EN, when defined, compiles in a watchdog: if WAIT_BUSY lasts BUSY_TIMEOUT clocks without adc_busy=1, set adc_timeout and return to IDLE with no FIFO push.
REQ-024 Without ADC_SCHED_TIMEOUT_EN, WAIT_BUSY waits indefinitely and adc_timeout is tied to 0.

Verification
REQ-025 Test: run=1, rate_div=1000, ADC model busy 70 clocks -> adc_trigger every 1000 clocks; one FIFO push per trigger; sample values match the model.
REQ-026 Test: rate_div=10 -> effective period 128 clocks between adc_trigger pulses.
REQ-027 Test: sample_ready=0, 5 conversions, FIFO_DEPTH=4 -> fifo_level=4, overrun=1, head equals first sample; clear_flags -> overrun=0.
REQ-028 Test: full FIFO with sample_ready=1 in the CAPTURE cycle -> level stays 4, overrun=0, oldest sample popped.
REQ-029 Test: busy model 300 clocks, rate_div=128 -> tick_slip=1, conversions continue back-to-back.
REQ-030 Test: with ADC_SCHED_TIMEOUT_EN defined and adc_busy stuck at 0 -> adc_timeout=1 after 255 clocks in WAIT_BUSY, FSM in IDLE, no push; reset mid-CONVERT -> all outputs at reset values next clock.
